uart_rx_fifo: RTL and testbench

Receive-side byte buffer sitting directly downstream of the UART receiver FSM/shift register. Captures each completed frame byte on the receiver's one-cycle `rx_done` pulse, stores it in a circular FIFO, and presents it to the consumer through a first-word-fall-through valid/ready interface. Flags overflow and the receiver's framing-error state so firmware or a parser can recover without losing sync.

---
 rtl/uart_rx_fifo_if.sv | 31 +++
 rtl/uart_rx_fifo.sv | 109 ++++++++++
 tb/tb_uart_rx_fifo.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Bundle between the UART receiver, the receive FIFO and its consumer.
// The master side is the receiver and consumer; the slave side is the FIFO.
interface uart_rx_fifo_if #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_done;
  logic                  rx_error;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  almost_full;
  logic                  overflow;
  logic                  frame_err;
  logic                  clr_flags;

  modport master (
    output rx_data, rx_done, rx_error, out_ready, clr_flags,
    input  out_data, out_valid, count, full, almost_full, overflow, frame_err
  );

  modport slave (
    input  rx_data, rx_done, rx_error, out_ready, clr_flags,
    output out_data, out_valid, count, full, almost_full, overflow, frame_err
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver. Bytes are captured on the
// receiver's rx_done pulse and presented first-word-fall-through to the
// consumer. Sticky overflow and framing-error flags let software resync.
module uart_rx_fifo #(
  parameter int DEPTH       = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int ALMOST_FULL = DEPTH - 2
) (
  input  logic                  clk,
  input  logic                  rst,       // synchronous, active-low
  input  logic                  soft_rst,  // synchronous flush, active-high
  uart_rx_fifo_if.slave         bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wp_q, wp_d;
  logic [AW-1:0]         rp_q, rp_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  frame_err_q, frame_err_d;
  logic                  rx_error_q, rx_error_d;

  logic flush;
  logic is_full;
  logic is_valid;
  logic rd;
  logic wr;
  logic ovf_set;
  logic fe_set;

  // Status decodes come straight from the registered occupancy.
  assign flush    = !rst || soft_rst;
  assign is_full  = (count_q == CW'(DEPTH));
  assign is_valid = (count_q != '0);

  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign rd      = is_valid && bus.out_ready && !flush;
  assign wr      = bus.rx_done && (!is_full || rd) && !flush;
  assign ovf_set = bus.rx_done && is_full && !rd;
  assign fe_set  = bus.rx_error && !rx_error_q;

  // Next-state for pointers, occupancy and sticky flags.
  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    wp_d        = wp_q;
    rp_d        = rp_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    frame_err_d = frame_err_q;
    rx_error_d  = bus.rx_error;
    if (soft_rst) begin
      wp_d        = '0;
      rp_d        = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      frame_err_d = 1'b0;
      rx_error_d  = 1'b0;
    end else begin
      if (wr) wp_d = wp_q + AW'(1);
      if (rd) rp_d = rp_q + AW'(1);
      case ({wr, rd})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      // A set event in the same cycle as clr_flags wins.
      if (ovf_set)             overflow_d = 1'b1;
      else if (bus.clr_flags)  overflow_d = 1'b0;
      if (fe_set)              frame_err_d = 1'b1;
      else if (bus.clr_flags)  frame_err_d = 1'b0;
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst) begin
      wp_q        <= '0;
      rp_q        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_error_q  <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
      rx_error_q  <= rx_error_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; pointers and count define validity.
    if (wr) mem_q[wp_q] <= bus.rx_data;
  end

  assign bus.out_data    = mem_q[rp_q];
  assign bus.out_valid   = is_valid;
  assign bus.count       = count_q;
  assign bus.full        = is_full;
  assign bus.almost_full = (count_q >= CW'(ALMOST_FULL));
  assign bus.overflow    = overflow_q;
  assign bus.frame_err   = frame_err_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=8, ALMOST_FULL=6).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst;
  logic soft_rst;
  int   checks   = 0;
  int   failures = 0;

  uart_rx_fifo_if #(.DEPTH(8), .DATA_WIDTH(8)) bus ();

  uart_rx_fifo #(.DEPTH(8), .DATA_WIDTH(8), .ALMOST_FULL(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .soft_rst (soft_rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    step();
    bus.rx_done = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, {31'd0, bus.out_valid}, 32'd1);
    check(tag, {24'd0, bus.out_data}, {24'd0, exp});
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_rd;
    rst = 1'b0;
    soft_rst = 1'b0;
    bus.rx_data = 8'h33;
    bus.rx_done = 1'b1;
    bus.rx_error = 1'b0;
    bus.out_ready = 1'b0;
    bus.clr_flags = 1'b0;

    // Reset held 3 cycles with rx_done active
    repeat (3) step();
    check("rst_count", {28'd0, bus.count}, 32'd0);
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_full", {31'd0, bus.full}, 32'd0);
    check("rst_afull", {31'd0, bus.almost_full}, 32'd0);
    check("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    check("rst_ferr", {31'd0, bus.frame_err}, 32'd0);
    bus.rx_done = 1'b0;
    rst = 1'b1;
    step();
    check("idle_valid", {31'd0, bus.out_valid}, 32'd0);
    push(8'hA5);
    check("a5_count", {28'd0, bus.count}, 32'd1);
    pop_check("a5_data", 8'hA5);
    check("a5_empty", {28'd0, bus.count}, 32'd0);

    // Order and wrap: 4 pushes to prime, then push+pop per cycle, then drain
    exp_rd = 8'h01;
    for (int i = 1; i <= 12; i++) begin
      bus.rx_data = 8'(i);
      bus.rx_done = 1'b1;
      bus.out_ready = (i > 4);
      if (i > 4) begin
        check("wrap_data", {24'd0, bus.out_data}, {24'd0, exp_rd});
        exp_rd++;
      end
      step();
    end
    bus.rx_done = 1'b0;
    bus.out_ready = 1'b0;
    check("wrap_count", {28'd0, bus.count}, 32'd4);
    for (int k = 0; k < 4; k++) begin
      pop_check("wrap_drain", exp_rd);
      exp_rd++;
    end
    check("wrap_empty", {28'd0, bus.count}, 32'd0);
    check("wrap_ovf", {31'd0, bus.overflow}, 32'd0);

    // Fill and overflow
    for (int i = 0; i < 9; i++) begin
      push(8'h10 + 8'(i));
      if (i == 4) check("afull_5", {31'd0, bus.almost_full}, 32'd0);
      if (i == 5) check("afull_6", {31'd0, bus.almost_full}, 32'd1);
      if (i == 6) check("full_7", {31'd0, bus.full}, 32'd0);
      if (i == 7) check("full_8", {31'd0, bus.full}, 32'd1);
      if (i == 7) check("ovf_pre", {31'd0, bus.overflow}, 32'd0);
    end
    check("ovf_set", {31'd0, bus.overflow}, 32'd1);
    check("ovf_count", {28'd0, bus.count}, 32'd8);
    for (int k = 0; k < 8; k++) pop_check("fill_drain", 8'h10 + 8'(k));
    check("fill_empty", {31'd0, bus.out_valid}, 32'd0);
    check("ovf_sticky", {31'd0, bus.overflow}, 32'd1);
    bus.clr_flags = 1'b1;
    step();
    bus.clr_flags = 1'b0;
    check("ovf_clr", {31'd0, bus.overflow}, 32'd0);

    // Full with simultaneous read and write
    for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
    bus.rx_data = 8'h55;
    bus.rx_done = 1'b1;
    bus.out_ready = 1'b1;
    check("sim_head", {24'd0, bus.out_data}, 32'h20);
    step();
    bus.rx_done = 1'b0;
    bus.out_ready = 1'b0;
    check("sim_count", {28'd0, bus.count}, 32'd8);
    check("sim_ovf", {31'd0, bus.overflow}, 32'd0);
    // Overflow while full, then set and clear in the same cycle: set wins
    push(8'h66);
    check("drop_ovf", {31'd0, bus.overflow}, 32'd1);
    bus.clr_flags = 1'b1;
    push(8'h67);
    check("setwins_ovf", {31'd0, bus.overflow}, 32'd1);
    step();
    bus.clr_flags = 1'b0;
    check("clr_ovf2", {31'd0, bus.overflow}, 32'd0);
    for (int k = 1; k < 8; k++) pop_check("sim_drain", 8'h20 + 8'(k));
    pop_check("sim_last", 8'h55);
    check("sim_empty", {28'd0, bus.count}, 32'd0);

    // Framing error edge detection
    check("fe_idle", {31'd0, bus.frame_err}, 32'd0);
    bus.rx_error = 1'b1;
    step();
    check("fe_set", {31'd0, bus.frame_err}, 32'd1);
    repeat (5) step();
    bus.clr_flags = 1'b1;
    step();
    bus.clr_flags = 1'b0;
    check("fe_clr", {31'd0, bus.frame_err}, 32'd0);
    repeat (13) step();
    check("fe_held", {31'd0, bus.frame_err}, 32'd0);
    bus.rx_error = 1'b0;
    step();
    check("fe_drop", {31'd0, bus.frame_err}, 32'd0);
    bus.rx_error = 1'b1;
    step();
    check("fe_reset", {31'd0, bus.frame_err}, 32'd1);
    bus.rx_error = 1'b0;
    step();

    // Flush mid-stream with concurrent write and read
    for (int i = 0; i < 5; i++) push(8'h30 + 8'(i));
    check("fl_count5", {28'd0, bus.count}, 32'd5);
    soft_rst = 1'b1;
    bus.rx_data = 8'h77;
    bus.rx_done = 1'b1;
    bus.out_ready = 1'b1;
    step();
    soft_rst = 1'b0;
    bus.rx_done = 1'b0;
    bus.out_ready = 1'b0;
    check("fl_count", {28'd0, bus.count}, 32'd0);
    check("fl_valid", {31'd0, bus.out_valid}, 32'd0);
    check("fl_ferr", {31'd0, bus.frame_err}, 32'd0);
    step();
    check("fl_still", {28'd0, bus.count}, 32'd0);
    push(8'h88);
    check("fl_after", {28'd0, bus.count}, 32'd1);
    pop_check("fl_data", 8'h88);
    check("fl_end", {28'd0, bus.count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
